sysid_check_ctrl: RTL and testbench

Boot-time sequencer and access arbiter for the SoC system-ID slave. After start, it reads the slave's ID word (address 0) and build-timestamp word (address 1), latches both, and compares them against the values expected by the loaded firmware. It reports pass or fail to the boot logic. It also shares the slave's single read port with a debug requester, so the slave has exactly one master.

---
 rtl/sysid_check_ctrl_if.sv | 34 +++
 rtl/sysid_check_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_check_ctrl_if.sv
// System-ID slave read port plus the debug requester port.
// The controller takes the master side and the environment takes the slave side.
interface sysid_check_ctrl_if;
   logic        sysid_address;
   logic        sysid_read;
   logic [31:0] sysid_readdata;
   logic        dbg_req;
   logic        dbg_addr;
   logic        dbg_gnt;
   logic [31:0] dbg_rdata;
   logic        dbg_rvalid;

   modport master (
      output sysid_address,
      output sysid_read,
      input  sysid_readdata,
      input  dbg_req,
      input  dbg_addr,
      output dbg_gnt,
      output dbg_rdata,
      output dbg_rvalid
   );

   modport slave (
      input  sysid_address,
      input  sysid_read,
      output sysid_readdata,
      output dbg_req,
      output dbg_addr,
      input  dbg_gnt,
      input  dbg_rdata,
      input  dbg_rvalid
   );
endinterface

// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID check sequencer and single-master arbiter for the
// system-ID slave. It reads the ID word (address 0) and the timestamp word
// (address 1), compares both against the expected values, and reports
// pass/fail. Debug reads are serviced whenever no check is running.
// Optional feature macro: SYSID_AUTOSTART_EN issues one internal start in
// the first cycle after reset deasserts.
module sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID  = 32'd0,
   parameter logic [31:0] EXPECTED_TS  = 32'd1668911089,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   sysid_check_ctrl_if.master  bus,
   output logic [31:0]         id_word,
   output logic [31:0]         ts_word,
   output logic                busy,
   output logic                check_done,
   output logic                check_pass
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_ID = 3'd1,
      S_RD_TS = 3'd2,
      S_CMP   = 3'd3,
      S_DONE  = 3'd4,
      S_DBG   = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic              ret_done_q, ret_done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dbg_addr_q, dbg_addr_d;
   logic              addr_q, addr_d;
   logic              read_q, read_d;
   logic [31:0]       id_q, id_d;
   logic [31:0]       ts_q, ts_d;
   logic [31:0]       drd_q, drd_d;
   logic              gnt_q, gnt_d;
   logic              rvalid_q, rvalid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              start_c;
   logic              last_c;

`ifdef SYSID_AUTOSTART_EN
   logic arm_q, arm_d;
   logic auto_q, auto_d;

   // One-shot: armed during reset, fires a single start one cycle after release.
   always_comb begin
      arm_d  = 1'b0;
      auto_d = arm_q;
   end

   // Autostart one-shot registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         arm_q  <= 1'b1;
         auto_q <= 1'b0;
      end else begin
         arm_q  <= arm_d;
         auto_q <= auto_d;
      end
   end

   assign start_c = start | auto_q;
`else
   assign start_c = start;
`endif

   assign last_c = (cnt_q == CNT_LAST);

   // Next-state, result capture and next-cycle port values.
   always_comb begin
      state_d    = state_q;
      ret_done_d = ret_done_q;
      cnt_d      = cnt_q;
      dbg_addr_d = dbg_addr_q;
      id_d       = id_q;
      ts_d       = ts_q;
      drd_d      = drd_q;
      done_d     = done_q;
      pass_d     = pass_q;
      gnt_d      = 1'b0;
      rvalid_d   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_c) begin
               state_d = S_RD_ID;
               cnt_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (bus.dbg_req) begin
               state_d    = S_DBG;
               cnt_d      = '0;
               gnt_d      = 1'b1;
               dbg_addr_d = bus.dbg_addr;
               ret_done_d = (state_q == S_DONE);
            end
         end
         S_RD_ID: begin
            if (last_c) begin
               id_d    = bus.sysid_readdata;
               cnt_d   = '0;
               state_d = S_RD_TS;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RD_TS: begin
            if (last_c) begin
               ts_d    = bus.sysid_readdata;
               cnt_d   = '0;
               state_d = S_CMP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CMP: begin
            // Results are final here, so a waiting debug request can be granted
            // in the same step instead of idling one cycle in DONE.
            pass_d = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
            done_d = 1'b1;
            if (bus.dbg_req) begin
               state_d    = S_DBG;
               cnt_d      = '0;
               gnt_d      = 1'b1;
               dbg_addr_d = bus.dbg_addr;
               ret_done_d = 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DBG: begin
            if (last_c) begin
               drd_d    = bus.sysid_readdata;
               rvalid_d = 1'b1;
               cnt_d    = '0;
               state_d  = ret_done_q ? S_DONE : S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      read_d = (state_d == S_RD_ID) || (state_d == S_RD_TS) || (state_d == S_DBG);
      addr_d = (state_d == S_RD_TS) || ((state_d == S_DBG) && dbg_addr_d);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ret_done_q <= 1'b0;
         cnt_q      <= '0;
         dbg_addr_q <= 1'b0;
         addr_q     <= 1'b0;
         read_q     <= 1'b0;
         id_q       <= '0;
         ts_q       <= '0;
         drd_q      <= '0;
         gnt_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_done_q <= ret_done_d;
         cnt_q      <= cnt_d;
         dbg_addr_q <= dbg_addr_d;
         addr_q     <= addr_d;
         read_q     <= read_d;
         id_q       <= id_d;
         ts_q       <= ts_d;
         drd_q      <= drd_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign bus.sysid_address = addr_q;
   assign bus.sysid_read    = read_q;
   assign bus.dbg_gnt       = gnt_q;
   assign bus.dbg_rdata     = drd_q;
   assign bus.dbg_rvalid    = rvalid_q;
   assign id_word           = id_q;
   assign ts_word           = ts_q;
   assign busy              = busy_q;
   assign check_done        = done_q;
   assign check_pass        = pass_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: directed scenarios with literal expectations
// followed by randomized start/debug/reset traffic against a timeline model.
module tb_sysid_check_ctrl;

   localparam int          L      = 3;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1668911089;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] id_word, ts_word;
   logic        busy, check_done, check_pass;
   logic [31:0] mem [2];
   logic [31:0] junk;

   int cyc         = 0;
   int vectors     = 0;
   int miscompares = 0;

   sysid_check_ctrl_if bus ();

   // Slave: returns its word while read is high, noise otherwise.
   assign bus.sysid_readdata = bus.sysid_read ? mem[bus.sysid_address] : junk;

   sysid_check_ctrl #(
      .EXPECTED_ID  (EXP_ID),
      .EXPECTED_TS  (EXP_TS),
      .READ_LATENCY (L)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .id_word    (id_word),
      .ts_word    (ts_word),
      .busy       (busy),
      .check_done (check_done),
      .check_pass (check_pass)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got %0d cycles required fewer", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- timeline reference model + per-cycle compare ----------
   typedef enum {M_IDLE, M_CHECK, M_DBG} act_e;

   act_e        act     = M_IDLE;
   int          t0      = 0;
   logic        cap     = 1'b0;
   logic        rv_next = 1'b0;
   logic        rst1    = 1'b0;
   logic        rst2    = 1'b0;
   logic [31:0] e_id = '0, e_ts = '0, e_drd = '0;
   logic        e_done = 1'b0, e_pass = 1'b0;
   logic        x_read = 1'b0, x_addr = 1'b0, x_busy = 1'b0, x_gnt = 1'b0, x_rv = 1'b0;

   always @(negedge clock) begin : model_cmp
      int   k;
      logic auto_s;

      vectors++;
      if ({bus.sysid_read, bus.sysid_address, bus.dbg_gnt, bus.dbg_rvalid, busy,
           check_done, check_pass, id_word, ts_word, bus.dbg_rdata} !==
          {x_read, x_addr, x_gnt, x_rv, x_busy, e_done, e_pass, e_id, e_ts, e_drd}) begin
         miscompares++;
         $display("FAIL cycle %0d outputs: got rd=%b ad=%b gnt=%b rv=%b busy=%b done=%b pass=%b id=%h ts=%h drd=%h, expected rd=%b ad=%b gnt=%b rv=%b busy=%b done=%b pass=%b id=%h ts=%h drd=%h",
                  cyc, bus.sysid_read, bus.sysid_address, bus.dbg_gnt, bus.dbg_rvalid, busy,
                  check_done, check_pass, id_word, ts_word, bus.dbg_rdata,
                  x_read, x_addr, x_gnt, x_rv, x_busy, e_done, e_pass, e_id, e_ts, e_drd);
      end

`ifdef SYSID_AUTOSTART_EN
      auto_s = !reset && !rst1 && rst2;
`else
      auto_s = 1'b0;
`endif

      // advance one cycle using inputs seen in this cycle
      k       = cyc - t0;
      rv_next = 1'b0;
      if (reset) begin
         act    = M_IDLE;
         e_id   = '0;
         e_ts   = '0;
         e_drd  = '0;
         e_done = 1'b0;
         e_pass = 1'b0;
      end else begin
         case (act)
            M_IDLE: begin
               if (start || auto_s) begin
                  act    = M_CHECK;
                  t0     = cyc + 1;
                  e_done = 1'b0;
                  e_pass = 1'b0;
               end else if (bus.dbg_req) begin
                  act = M_DBG;
                  t0  = cyc + 1;
                  cap = bus.dbg_addr;
               end
            end
            M_CHECK: begin
               if (k == L - 1)     e_id = mem[0];
               if (k == 2 * L - 1) e_ts = mem[1];
               if (k == 2 * L) begin
                  e_pass = (e_id == EXP_ID) && (e_ts == EXP_TS);
                  e_done = 1'b1;
                  if (bus.dbg_req) begin
                     act = M_DBG;
                     t0  = cyc + 1;
                     cap = bus.dbg_addr;
                  end else begin
                     act = M_IDLE;
                  end
               end
            end
            default: begin
               if (k == L - 1) begin
                  e_drd   = mem[cap];
                  rv_next = 1'b1;
                  act     = M_IDLE;
               end
            end
         endcase
      end
      rst2 = rst1;
      rst1 = reset;

      // port values for the next cycle from position in the activity window
      k      = cyc + 1 - t0;
      x_read = 1'b0;
      x_addr = 1'b0;
      x_busy = 1'b0;
      x_gnt  = 1'b0;
      x_rv   = rv_next;
      if (act == M_CHECK) begin
         x_busy = 1'b1;
         if (k < L) begin
            x_read = 1'b1;
         end else if (k < 2 * L) begin
            x_read = 1'b1;
            x_addr = 1'b1;
         end
      end else if (act == M_DBG) begin
         x_busy = 1'b1;
         x_read = 1'b1;
         x_addr = cap;
         x_gnt  = (k == 0);
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic start_pulse(output int n);
      n     = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic settle();
      repeat (2 * L + 4) tick();
   endtask

   // ---------------- stimulus and literal expectations ----------------
   initial begin : main
      int n;
      int r;
      int rises;
      logic prev;
      int idx;

      bus.dbg_req  = 1'b0;
      bus.dbg_addr = 1'b0;
      mem[0]       = EXP_ID;
      mem[1]       = EXP_TS;
      junk         = 32'hA5A5_5A5A;

      repeat (3) tick();
      at_neg();
      chk("reset busy",    32'(busy), 32'd0);
      chk("reset id_word", id_word, 32'd0);
      chk("reset done",    32'(check_done), 32'd0);
      chk("reset read",    32'(bus.sysid_read), 32'd0);
      tick();
      reset = 1'b0;
      r     = cyc;
`ifdef SYSID_AUTOSTART_EN
      wait_until(r + 2 * L + 2);
      at_neg();
      chk("autostart done early", 32'(check_done), 32'd0);
      tick();
      at_neg();
      chk("autostart done", 32'(check_done), 32'd1);
      chk("autostart pass", 32'(check_pass), 32'd1);
      tick();
`else
      wait_until(r + 100);
      at_neg();
      chk("no autostart done", 32'(check_done), 32'd0);
      chk("no autostart busy", 32'(busy), 32'd0);
      tick();
`endif
      settle();

      // A: matching words
      start_pulse(n);
      wait_until(n + 2 * L + 1);
      at_neg();
      chk("A done in CMP", 32'(check_done), 32'd0);
      chk("A busy in CMP", 32'(busy), 32'd1);
      tick();
      at_neg();
      chk("A done", 32'(check_done), 32'd1);
      chk("A pass", 32'(check_pass), 32'd1);
      chk("A id_word", id_word, 32'd0);
      chk("A ts_word", ts_word, 32'd1668911089);
      chk("A busy after", 32'(busy), 32'd0);
      tick();

      // B: wrong timestamp
      mem[1] = 32'h1234_5678;
      start_pulse(n);
      wait_until(n + 2 * L + 2);
      at_neg();
      chk("B done", 32'(check_done), 32'd1);
      chk("B pass", 32'(check_pass), 32'd0);
      chk("B ts_word", ts_word, 32'h1234_5678);
      tick();

      // C: start and debug request together, start wins
      mem[1]       = EXP_TS;
      n            = cyc;
      start        = 1'b1;
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 1'b1;
      tick();
      start = 1'b0;
      wait_until(n + 2 * L + 1);
      at_neg();
      chk("C gnt early", 32'(bus.dbg_gnt), 32'd0);
      tick();
      at_neg();
      chk("C gnt", 32'(bus.dbg_gnt), 32'd1);
      chk("C done", 32'(check_done), 32'd1);
      chk("C pass", 32'(check_pass), 32'd1);
      tick();
      bus.dbg_req = 1'b0;
      wait_until(n + 3 * L + 1);
      at_neg();
      chk("C rvalid early", 32'(bus.dbg_rvalid), 32'd0);
      tick();
      at_neg();
      chk("C rvalid", 32'(bus.dbg_rvalid), 32'd1);
      chk("C rdata", bus.dbg_rdata, 32'd1668911089);
      tick();

      // D: reset during the timestamp read
      mem[0] = 32'hDEAD_BEEF;
      start_pulse(n);
      wait_until(n + L + 1);
      reset = 1'b1;
      at_neg();
      chk("D id before reset", id_word, 32'hDEAD_BEEF);
      chk("D addr in RD_TS", 32'(bus.sysid_address), 32'd1);
      tick();
      at_neg();
      chk("D id after reset", id_word, 32'd0);
      chk("D busy after reset", 32'(busy), 32'd0);
      chk("D read after reset", 32'(bus.sysid_read), 32'd0);
      chk("D done after reset", 32'(check_done), 32'd0);
      tick();
      reset = 1'b0;
      settle();
      mem[0] = EXP_ID;
      start_pulse(n);
      wait_until(n + 2 * L + 2);
      at_neg();
      chk("D rerun done", 32'(check_done), 32'd1);
      chk("D rerun pass", 32'(check_pass), 32'd1);
      tick();

      // E: start pulses while busy are dropped
      start_pulse(n);
      prev  = 1'b0;
      rises = 0;
      for (int c = 1; c <= 2 * L + 6; c++) begin
         start = (c == 2) || (c == 2 * L + 1);
         at_neg();
         if (check_done && !prev) rises++;
         prev = check_done;
         if (c == 2 * L + 1) chk("E done in CMP", 32'(check_done), 32'd0);
         if (c == 2 * L + 2) chk("E done", 32'(check_done), 32'd1);
         tick();
      end
      start = 1'b0;
      chk("E done rises", 32'(rises), 32'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (bus.dbg_req && bus.dbg_gnt) begin
            bus.dbg_req = 1'b0;
         end else if (!bus.dbg_req && $urandom_range(0, 5) == 0) begin
            bus.dbg_req  = 1'b1;
            bus.dbg_addr = 1'($urandom_range(0, 1));
         end
         start = ($urandom_range(0, 9) == 0);
         if (reset) reset = ($urandom_range(0, 2) == 0);
         else       reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) begin
            idx = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) mem[idx] = (idx == 1) ? EXP_TS : EXP_ID;
            else                           mem[idx] = $urandom;
         end
         junk = $urandom;
         tick();
      end

      start       = 1'b0;
      reset       = 1'b0;
      bus.dbg_req = 1'b0;
      repeat (2 * L + 6) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
